// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-channel, W-bit multiplexer with break-before-make
// select switching and an optional auto-scan mode.
//
// Build option: define MUX_SCAN_EN to compile in the auto-scan mode (mode input,
// dwell counter, DWELL parameter). Without it the block is manual-only and the
// mode input is ignored.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i        in   CH*WIDTH channel inputs, channel k = i[k*WIDTH +: WIDTH]
//   s        in   requested channel (manual mode)
//   s_valid  in   s is presented
//   s_ready  out  block can accept a new s
//   mode     in   0 = manual, 1 = auto-scan
//   o        out  registered selected channel data (0 while blanking)
//   o_valid  out  o carries live channel data
//   cur_sel  out  channel currently routed or being switched to
//
// state | meaning
// HOLD  | o tracks channel cur_sel every edge
// BLANK | o forced 0 for BLANK cycles after a channel change

module mux_scan_reg #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 2,
  parameter int BLANK = 2,
  parameter int DWELL = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [(2**SEL_W)*WIDTH-1:0] i,
  input  logic [SEL_W-1:0]            s,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        mode,
  output logic [WIDTH-1:0]            o,
  output logic                        o_valid,
  output logic [SEL_W-1:0]            cur_sel
);

  localparam int BL_W = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'((BLANK > 0) ? BLANK - 1 : 0);

  typedef enum logic {S_HOLD, S_BLANK} state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [WIDTH-1:0]  o_nxt;
  logic              ov_nxt;
  logic [BL_W-1:0]   bcnt, bcnt_nxt;
  logic [WIDTH-1:0]  ch_data;
  logic              scan_on;
  logic              change;
  logic [SEL_W-1:0]  new_sel;

`ifdef MUX_SCAN_EN
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  logic [DW_W-1:0] dwell, dwell_nxt;
  logic            mode_q;

  assign scan_on = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign scan_on = 1'b0;
`endif

  assign ch_data = i[cur_sel*WIDTH +: WIDTH];

  // o_valid is low only in reset and blanking, so it also masks the first
  // cycle after reset release.
  assign s_ready = (state == S_HOLD) && o_valid && !scan_on;

  always_comb begin
    state_nxt = state;
    sel_nxt   = cur_sel;
    o_nxt     = o;
    ov_nxt    = o_valid;
    bcnt_nxt  = bcnt;
    change    = 1'b0;
    new_sel   = cur_sel;
`ifdef MUX_SCAN_EN
    dwell_nxt = dwell;
`endif
    case (state)
      S_HOLD: begin
        o_nxt  = ch_data;
        ov_nxt = 1'b1;
        if (s_valid && s_ready) begin
          if (s != cur_sel) begin
            change  = 1'b1;
            new_sel = s;
          end
        end
`ifdef MUX_SCAN_EN
        // The load edge after reset does not count toward the dwell, so each
        // channel is shown for DWELL cycles including the first.
        else if (scan_on && o_valid) begin
          if (dwell == DW_LAST) begin
            change  = 1'b1;
            new_sel = SEL_W'(cur_sel + 1'b1);
          end else begin
            dwell_nxt = DW_W'(dwell + 1'b1);
          end
        end
`endif
        if (change) begin
          sel_nxt = new_sel;
`ifdef MUX_SCAN_EN
          dwell_nxt = '0;
`endif
          if (BLANK > 0) begin
            state_nxt = S_BLANK;
            o_nxt     = '0;
            ov_nxt    = 1'b0;
            bcnt_nxt  = '0;
          end
        end
      end
      S_BLANK: begin
        o_nxt  = '0;
        ov_nxt = 1'b0;
        if (bcnt == BL_LAST) begin
          state_nxt = S_HOLD;
          o_nxt     = ch_data;
          ov_nxt    = 1'b1;
          bcnt_nxt  = '0;
        end else begin
          bcnt_nxt = BL_W'(bcnt + 1'b1);
        end
      end
      default: begin
        state_nxt = S_HOLD;
      end
    endcase
`ifdef MUX_SCAN_EN
    if (mode != mode_q) dwell_nxt = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_HOLD;
      cur_sel <= '0;
      o       <= '0;
      o_valid <= 1'b0;
      bcnt    <= '0;
`ifdef MUX_SCAN_EN
      dwell   <= '0;
      mode_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cur_sel <= sel_nxt;
      o       <= o_nxt;
      o_valid <= ov_nxt;
      bcnt    <= bcnt_nxt;
`ifdef MUX_SCAN_EN
      dwell   <= dwell_nxt;
      mode_q  <= mode;
`endif
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
module tb_mux_scan_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i;
  logic [1:0]  s;
  logic        s_valid;
  logic        s_ready;
  logic        mode;
  logic [7:0]  o;
  logic        o_valid;
  logic [1:0]  cur_sel;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] o;
    logic       ov;
    logic [1:0] sel;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  mux_scan_reg #(.WIDTH(8), .SEL_W(2), .BLANK(2), .DWELL(4)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .s(s), .s_valid(s_valid),
    .s_ready(s_ready), .mode(mode), .o(o), .o_valid(o_valid), .cur_sel(cur_sel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] chan(input int k);
    logic [31:0] d;
    d = 32'h44332211;
    return d[(k % 4)*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".o"}, o, e.o);
    chk({tag, ".o_valid"}, {7'd0, o_valid}, {7'd0, e.ov});
    chk({tag, ".cur_sel"}, {6'd0, cur_sel}, {6'd0, e.sel});
    chk({tag, ".s_ready"}, {7'd0, s_ready}, {7'd0, e.rdy});
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic cyc(input string tag, input logic [7:0] eo, input logic eov,
                     input logic [1:0] esel, input logic erdy);
    exp_t e;
    sb.push_back('{o: eo, ov: eov, sel: esel, rdy: erdy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  initial begin
    rst_n   = 1'b0;
    i       = 32'h44332211;
    s       = 2'd0;
    s_valid = 1'b0;
    mode    = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '{o: 8'h00, ov: 1'b0, sel: 2'd0, rdy: 1'b0});
    rst_n = 1'b1;
    cyc("release", 8'h11, 1'b1, 2'd0, 1'b1);

    // one-cycle latency from i to o
    i[7:0] = 8'h55;
    cyc("lat_new", 8'h55, 1'b1, 2'd0, 1'b1);
    i[7:0] = 8'h11;
    cyc("lat_old", 8'h11, 1'b1, 2'd0, 1'b1);

    // manual switch to channel 2 with two blank cycles
    s = 2'd2; s_valid = 1'b1;
    cyc("sw2_acc", 8'h00, 1'b0, 2'd2, 1'b0);
    s_valid = 1'b0;
    cyc("sw2_blk", 8'h00, 1'b0, 2'd2, 1'b0);
    cyc("sw2_live", 8'h33, 1'b1, 2'd2, 1'b1);

    // request for the channel already selected: no blanking
    s = 2'd2; s_valid = 1'b1;
    cyc("same_acc", 8'h33, 1'b1, 2'd2, 1'b1);
    s_valid = 1'b0;
    cyc("same_hold", 8'h33, 1'b1, 2'd2, 1'b1);

    // switch to 3; a request during blanking is not taken
    s = 2'd3; s_valid = 1'b1;
    cyc("sw3_acc", 8'h00, 1'b0, 2'd3, 1'b0);
    s = 2'd1;
    cyc("sw3_blk", 8'h00, 1'b0, 2'd3, 1'b0);
    s_valid = 1'b0;
    cyc("sw3_live", 8'h44, 1'b1, 2'd3, 1'b1);

    // back to channel 0
    s = 2'd0; s_valid = 1'b1;
    cyc("sw0_acc", 8'h00, 1'b0, 2'd0, 1'b0);
    s_valid = 1'b0;
    cyc("sw0_blk", 8'h00, 1'b0, 2'd0, 1'b0);
    cyc("sw0_live", 8'h11, 1'b1, 2'd0, 1'b1);

`ifdef MUX_SCAN_EN
    // auto-scan: 4 cycles per channel, 2 blank cycles between, wraps 3 -> 0
    mode = 1'b1;
    for (int n = 0; n < 4; n++) cyc("scan_c0", 8'h11, 1'b1, 2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      for (int n = 0; n < 2; n++) cyc("scan_blk", 8'h00, 1'b0, 2'(k % 4), 1'b0);
      for (int n = 0; n < 4; n++) cyc("scan_ch", chan(k), 1'b1, 2'(k % 4), 1'b0);
    end
    // back to manual: cur_sel kept, ready returns
    mode = 1'b0;
    cyc("scan_off", 8'h11, 1'b1, 2'd0, 1'b1);
    // mode=1 on the same edge as a request: request ignored
    mode = 1'b1; s = 2'd2; s_valid = 1'b1;
    cyc("mode_race", 8'h11, 1'b1, 2'd0, 1'b0);
    s_valid = 1'b0; mode = 1'b0;
    cyc("mode_race2", 8'h11, 1'b1, 2'd0, 1'b1);
`else
    // scan not built: mode ignored, manual requests still work
    mode = 1'b1;
    for (int n = 0; n < 6; n++) cyc("noscan_hold", 8'h11, 1'b1, 2'd0, 1'b1);
    s = 2'd1; s_valid = 1'b1;
    cyc("noscan_acc", 8'h00, 1'b0, 2'd1, 1'b0);
    s_valid = 1'b0;
    cyc("noscan_blk", 8'h00, 1'b0, 2'd1, 1'b0);
    cyc("noscan_live", 8'h22, 1'b1, 2'd1, 1'b1);
    s = 2'd0; s_valid = 1'b1;
    cyc("noscan_back", 8'h00, 1'b0, 2'd0, 1'b0);
    s_valid = 1'b0;
    cyc("noscan_blk2", 8'h00, 1'b0, 2'd0, 1'b0);
    cyc("noscan_live2", 8'h11, 1'b1, 2'd0, 1'b1);
    mode = 1'b0;
`endif

    // asynchronous reset in the middle of blanking
    s = 2'd1; s_valid = 1'b1;
    cyc("rst_acc", 8'h00, 1'b0, 2'd1, 1'b0);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", '{o: 8'h00, ov: 1'b0, sel: 2'd0, rdy: 1'b0});
    @(posedge clk);
    #1;
    chk_all("rst_held", '{o: 8'h00, ov: 1'b0, sel: 2'd0, rdy: 1'b0});
    rst_n = 1'b1;
    cyc("rst_rel", 8'h11, 1'b1, 2'd0, 1'b1);
    cyc("rst_hold", 8'h11, 1'b1, 2'd0, 1'b1);
    s = 2'd3; s_valid = 1'b1;
    cyc("rst_sw_acc", 8'h00, 1'b0, 2'd3, 1'b0);
    s_valid = 1'b0;
    cyc("rst_sw_blk", 8'h00, 1'b0, 2'd3, 1'b0);
    cyc("rst_sw_live", 8'h44, 1'b1, 2'd3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
